// File: rtl/io_seq_pkg.sv
// Shared definitions for the IO stimulus sequencer.
//  - op_e    : step-table operation encodings
//  - state_e : sequencer FSM states
//  - entry layout helpers: {op, mask, value, delay} packed MSB to LSB
package io_seq_pkg;

  typedef enum logic [1:0] {
    OP_SET_SW    = 2'd0,
    OP_PULSE_BTN = 2'd1,
    OP_WAIT_LED  = 2'd2,
    OP_END       = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec,
    StHold,
    StWait,
    StDone
  } state_e;

  localparam int unsigned OpWidth = 2;

  function automatic int unsigned entry_width(int unsigned sw_width, int unsigned delay_width);
    return OpWidth + 2 * sw_width + delay_width;
  endfunction

  function automatic int unsigned value_lsb(int unsigned delay_width);
    return delay_width;
  endfunction

  function automatic int unsigned mask_lsb(int unsigned sw_width, int unsigned delay_width);
    return delay_width + sw_width;
  endfunction

  function automatic int unsigned op_lsb(int unsigned sw_width, int unsigned delay_width);
    return delay_width + 2 * sw_width;
  endfunction

endpackage

// File: rtl/io_stimulus_sequencer_if.sv
// Bundle of the sequencer's control, table-config and board-facing signals.
//  master : bench / board side (drives start, cfg_*, leds_in)
//  slave  : the sequencer (drives sw_out, btn_out, busy, done, pass, step_idx)
interface io_stimulus_sequencer_if
  import io_seq_pkg::*;
#(
  parameter int unsigned SW_WIDTH    = 24,
  parameter int unsigned LED_WIDTH   = 24,
  parameter int unsigned BTN_WIDTH   = 5,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned DELAY_WIDTH = 16
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic                   start;
  logic                   cfg_we;
  logic [AW-1:0]          cfg_addr;
  op_e                    cfg_op;
  logic [SW_WIDTH-1:0]    cfg_mask;
  logic [SW_WIDTH-1:0]    cfg_value;
  logic [DELAY_WIDTH-1:0] cfg_delay;
  logic [LED_WIDTH-1:0]   leds_in;
  logic [SW_WIDTH-1:0]    sw_out;
  logic [BTN_WIDTH-1:0]   btn_out;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [AW-1:0]          step_idx;

  modport master (
    output start, cfg_we, cfg_addr, cfg_op, cfg_mask, cfg_value, cfg_delay, leds_in,
    input  sw_out, btn_out, busy, done, pass, step_idx
  );

  modport slave (
    input  start, cfg_we, cfg_addr, cfg_op, cfg_mask, cfg_value, cfg_delay, leds_in,
    output sw_out, btn_out, busy, done, pass, step_idx
  );

endinterface

// File: rtl/io_seq_table.sv
// Step-table register file: one synchronous write port, one combinational
// read port, no reset (contents survive a sequencer reset).
//  clk_i   : clock
//  we_i    : write strobe
//  waddr_i : write index
//  wdata_i : packed entry to store
//  raddr_i : read index
//  rdata_o : packed entry at raddr_i
module io_seq_table #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 66,
  localparam int unsigned Aw   = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [Aw-1:0]    waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [Aw-1:0]    raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/io_stimulus_sequencer.sv
// Table-driven stimulus engine for the Minisys top level. Each step sets
// switches, pulses buttons, waits for a light pattern, or ends the run.
//  Minisys_Clock : system clock, rising edge
//  Minisys_Rst_n : asynchronous active-low reset
//  seq_if        : control (start/busy/done/pass/step_idx), table write port
//                  (cfg_*), and board signals (leds_in, sw_out, btn_out)
module io_stimulus_sequencer
  import io_seq_pkg::*;
#(
  parameter int unsigned SW_WIDTH    = 24,
  parameter int unsigned LED_WIDTH   = 24,
  parameter int unsigned BTN_WIDTH   = 5,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned DELAY_WIDTH = 16
) (
  input logic                     Minisys_Clock,
  input logic                     Minisys_Rst_n,
  io_stimulus_sequencer_if.slave  seq_if
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned EntryW   = entry_width(SW_WIDTH, DELAY_WIDTH);
  localparam int unsigned ValueLsb = value_lsb(DELAY_WIDTH);
  localparam int unsigned MaskLsb  = mask_lsb(SW_WIDTH, DELAY_WIDTH);
  localparam int unsigned OpLsb    = op_lsb(SW_WIDTH, DELAY_WIDTH);

  state_e                 state_q, state_d;
  logic [AW-1:0]          step_q, step_d;
  op_e                    op_q, op_d;
  logic [SW_WIDTH-1:0]    mask_q, mask_d;
  logic [SW_WIDTH-1:0]    value_q, value_d;
  logic [DELAY_WIDTH-1:0] delay_q, delay_d;
  logic [DELAY_WIDTH-1:0] cnt_q, cnt_d;
  logic [SW_WIDTH-1:0]    sw_q, sw_d;
  logic [BTN_WIDTH-1:0]   btn_q, btn_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;

  logic [EntryW-1:0]      rd_entry;
  logic                   led_match;
  logic                   advance;

  // Table is frozen while a run is in progress.
  io_seq_table #(
    .Depth (DEPTH),
    .Width (EntryW)
  ) u_table (
    .clk_i   (Minisys_Clock),
    .we_i    (seq_if.cfg_we & ~busy_q),
    .waddr_i (seq_if.cfg_addr),
    .wdata_i ({seq_if.cfg_op, seq_if.cfg_mask, seq_if.cfg_value, seq_if.cfg_delay}),
    .raddr_i (step_q),
    .rdata_o (rd_entry)
  );

  assign led_match = ((seq_if.leds_in & mask_q[LED_WIDTH-1:0]) ==
                      (value_q[LED_WIDTH-1:0] & mask_q[LED_WIDTH-1:0]));

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    op_d    = op_q;
    mask_d  = mask_q;
    value_d = value_q;
    delay_d = delay_q;
    cnt_d   = cnt_q;
    sw_d    = sw_q;
    btn_d   = btn_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    advance = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (seq_if.start) begin
          step_d  = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        op_d    = op_e'(rd_entry[OpLsb +: OpWidth]);
        mask_d  = rd_entry[MaskLsb +: SW_WIDTH];
        value_d = rd_entry[ValueLsb +: SW_WIDTH];
        delay_d = rd_entry[DELAY_WIDTH-1:0];
        state_d = StExec;
      end
      StExec: begin
        cnt_d = delay_q;
        unique case (op_q)
          OP_SET_SW: begin
            sw_d    = (sw_q & ~mask_q) | (value_q & mask_q);
            state_d = StHold;
          end
          OP_PULSE_BTN: begin
            btn_d   = value_q[BTN_WIDTH-1:0];
            state_d = StHold;
          end
          OP_WAIT_LED: begin
            state_d = StWait;
          end
          OP_END: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = 1'b1;
            state_d = StDone;
          end
        endcase
      end
      StHold: begin
        // Leaving at cnt<=1 gives max(delay,1) hold cycles.
        if (cnt_q <= DELAY_WIDTH'(1)) begin
          if (op_q == OP_PULSE_BTN) begin
            btn_d = '0;
          end
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q - DELAY_WIDTH'(1);
        end
      end
      StWait: begin
        // A match wins over a timeout in the same cycle.
        if (led_match) begin
          advance = 1'b1;
        end else if (cnt_q == '0) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = 1'b0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - DELAY_WIDTH'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Running off the end of the table behaves as an END step.
    if (advance) begin
      if (step_q == AW'(DEPTH - 1)) begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = 1'b1;
        state_d = StDone;
      end else begin
        step_d  = step_q + AW'(1);
        state_d = StFetch;
      end
    end
  end

  always_ff @(posedge Minisys_Clock or negedge Minisys_Rst_n) begin
    if (!Minisys_Rst_n) begin
      state_q <= StIdle;
      step_q  <= '0;
      op_q    <= OP_SET_SW;
      mask_q  <= '0;
      value_q <= '0;
      delay_q <= '0;
      cnt_q   <= '0;
      sw_q    <= '0;
      btn_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      op_q    <= op_d;
      mask_q  <= mask_d;
      value_q <= value_d;
      delay_q <= delay_d;
      cnt_q   <= cnt_d;
      sw_q    <= sw_d;
      btn_q   <= btn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign seq_if.sw_out   = sw_q;
  assign seq_if.btn_out  = btn_q;
  assign seq_if.busy     = busy_q;
  assign seq_if.done     = done_q;
  assign seq_if.pass     = pass_q;
  assign seq_if.step_idx = step_q;

endmodule

// File: tb/tb_io_stimulus_sequencer.sv
// Directed bench for io_stimulus_sequencer. Edge numbers in comments count
// the edge that samples start as edge 1; outputs are sampled 1 ns after edges.
module tb_io_stimulus_sequencer;
  import io_seq_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   n;

  io_stimulus_sequencer_if bus_if ();

  io_stimulus_sequencer dut (
    .Minisys_Clock (clk),
    .Minisys_Rst_n (rst_n),
    .seq_if        (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [3:0] addr, input op_e op, input logic [23:0] mask,
                             input logic [23:0] value, input logic [15:0] dly);
    bus_if.cfg_addr  = addr;
    bus_if.cfg_op    = op;
    bus_if.cfg_mask  = mask;
    bus_if.cfg_value = value;
    bus_if.cfg_delay = dly;
    bus_if.cfg_we    = 1'b1;
    tick();
    bus_if.cfg_we    = 1'b0;
  endtask

  // Returns just after edge 1.
  task automatic start_run();
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
  endtask

  // Waits for done with a cycle budget; n tracks the edge number.
  task automatic wait_done(input int limit);
    while (!bus_if.done && n < limit) begin
      tick();
      n++;
    end
    if (!bus_if.done) begin
      checks++;
      errors++;
      $display("FAIL wait_done: got timeout at edge %0d expected done", n);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n            = 1'b1;
    bus_if.start     = 1'b0;
    bus_if.cfg_we    = 1'b0;
    bus_if.cfg_addr  = '0;
    bus_if.cfg_op    = OP_SET_SW;
    bus_if.cfg_mask  = '0;
    bus_if.cfg_value = '0;
    bus_if.cfg_delay = '0;
    bus_if.leds_in   = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_sw", 32'(bus_if.sw_out), 32'h0);
    check("rst_btn", 32'(bus_if.btn_out), 32'h0);
    check("rst_busy", 32'(bus_if.busy), 32'h0);
    check("rst_done", 32'(bus_if.done), 32'h0);
    check("rst_pass", 32'(bus_if.pass), 32'h0);
    check("rst_step", 32'(bus_if.step_idx), 32'h0);
    #9 rst_n = 1'b1;
    tick();

    // 1: lone END entry
    write_entry(4'd0, OP_END, 24'h0, 24'h0, 16'd0);
    start_run();
    check("t1_busy_e1", 32'(bus_if.busy), 32'h1);
    tick();
    check("t1_done_e2", 32'(bus_if.done), 32'h0);
    tick();
    check("t1_done_e3", 32'(bus_if.done), 32'h1);
    check("t1_pass", 32'(bus_if.pass), 32'h1);
    check("t1_busy", 32'(bus_if.busy), 32'h0);
    check("t1_sw", 32'(bus_if.sw_out), 32'h0);

    // 2: two SET_SW steps then END
    write_entry(4'd0, OP_SET_SW, 24'h200000, 24'h200000, 16'd4);
    write_entry(4'd1, OP_SET_SW, 24'h000003, 24'h000003, 16'd2);
    write_entry(4'd2, OP_END, 24'h0, 24'h0, 16'd0);
    start_run();
    check("t2_done_clr", 32'(bus_if.done), 32'h0);
    tick();
    check("t2_sw_e2", 32'(bus_if.sw_out), 32'h0);
    tick();
    check("t2_sw_e3", 32'(bus_if.sw_out), 32'h200000);
    repeat (5) tick();
    check("t2_sw_e8", 32'(bus_if.sw_out), 32'h200000);
    tick();
    check("t2_sw_e9", 32'(bus_if.sw_out), 32'h200003);
    repeat (3) tick();
    check("t2_done_e12", 32'(bus_if.done), 32'h0);
    tick();
    check("t2_done_e13", 32'(bus_if.done), 32'h1);
    check("t2_pass", 32'(bus_if.pass), 32'h1);
    check("t2_step", 32'(bus_if.step_idx), 32'h2);

    // 3: 5-cycle button pulse
    write_entry(4'd0, OP_PULSE_BTN, 24'h0, 24'h000008, 16'd5);
    write_entry(4'd1, OP_END, 24'h0, 24'h0, 16'd0);
    start_run();
    for (int e = 2; e <= 9; e++) begin
      tick();
      check($sformatf("t3_btn_e%0d", e), 32'(bus_if.btn_out), (e >= 3 && e <= 7) ? 32'h8 : 32'h0);
    end
    tick();
    check("t3_done", 32'(bus_if.done), 32'h1);
    check("t3_pass", 32'(bus_if.pass), 32'h1);

    // 4a: WAIT_LED matched at edge 40, upper bits outside the mask ignored
    write_entry(4'd0, OP_WAIT_LED, 24'h0000FF, 24'h00005A, 16'd100);
    write_entry(4'd1, OP_END, 24'h0, 24'h0, 16'd0);
    bus_if.leds_in = 24'h003C00;
    start_run();
    repeat (38) tick();
    check("t4_busy_e39", 32'(bus_if.busy), 32'h1);
    check("t4_step_e39", 32'(bus_if.step_idx), 32'h0);
    bus_if.leds_in = 24'h003C5A;
    tick();
    tick();
    check("t4_step_e41", 32'(bus_if.step_idx), 32'h1);
    check("t4_done_e41", 32'(bus_if.done), 32'h0);
    tick();
    check("t4_done_e42", 32'(bus_if.done), 32'h1);
    check("t4_pass", 32'(bus_if.pass), 32'h1);

    // 4b: WAIT_LED timeout, outputs keep their values
    write_entry(4'd0, OP_WAIT_LED, 24'h0000FF, 24'h00005A, 16'd10);
    bus_if.leds_in = 24'h000055;
    start_run();
    repeat (12) tick();
    check("t4b_done_e13", 32'(bus_if.done), 32'h0);
    tick();
    check("t4b_done_e14", 32'(bus_if.done), 32'h1);
    check("t4b_pass", 32'(bus_if.pass), 32'h0);
    check("t4b_busy", 32'(bus_if.busy), 32'h0);
    check("t4b_step", 32'(bus_if.step_idx), 32'h0);
    check("t4b_sw", 32'(bus_if.sw_out), 32'h200003);

    // 5: full table of SET_SW d=0, no END; write attempt during the run
    for (int i = 0; i < 16; i++) begin
      write_entry(4'(i), OP_SET_SW, 24'(1 << i), (i % 2 == 0) ? 24'(1 << i) : 24'h0, 16'd0);
    end
    start_run();
    bus_if.cfg_addr  = 4'd0;
    bus_if.cfg_op    = OP_END;
    bus_if.cfg_we    = 1'b1;
    tick();
    bus_if.cfg_we    = 1'b0;
    n = 2;
    wait_done(200);
    check("t5_done_edge", 32'(n), 32'd49);
    check("t5_pass", 32'(bus_if.pass), 32'h1);
    check("t5_step", 32'(bus_if.step_idx), 32'hF);
    check("t5_sw", 32'(bus_if.sw_out), 32'h205555);
    start_run();
    n = 1;
    repeat (9) begin
      tick();
      n++;
    end
    check("t5_rerun_busy", 32'(bus_if.busy), 32'h1);
    wait_done(200);
    check("t5_rerun_edge", 32'(n), 32'd49);
    check("t5_rerun_step", 32'(bus_if.step_idx), 32'hF);

    // 6: async reset during a button hold, then a fresh run
    write_entry(4'd0, OP_PULSE_BTN, 24'h0, 24'h000010, 16'd20);
    write_entry(4'd1, OP_END, 24'h0, 24'h0, 16'd0);
    start_run();
    repeat (2) tick();
    check("t6_btn_e3", 32'(bus_if.btn_out), 32'h10);
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_btn", 32'(bus_if.btn_out), 32'h0);
    check("t6_rst_busy", 32'(bus_if.busy), 32'h0);
    check("t6_rst_done", 32'(bus_if.done), 32'h0);
    check("t6_rst_sw", 32'(bus_if.sw_out), 32'h0);
    #3 rst_n = 1'b1;
    tick();
    check("t6_idle_busy", 32'(bus_if.busy), 32'h0);
    start_run();
    repeat (2) tick();
    check("t6_rerun_btn", 32'(bus_if.btn_out), 32'h10);
    check("t6_rerun_step", 32'(bus_if.step_idx), 32'h0);
    n = 3;
    wait_done(100);
    check("t6_done_edge", 32'(n), 32'd25);
    check("t6_pass", 32'(bus_if.pass), 32'h1);
    check("t6_step", 32'(bus_if.step_idx), 32'h1);
    check("t6_btn_end", 32'(bus_if.btn_out), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000 ns");
    $fatal(1, "watchdog");
  end

endmodule
